alarm_sched: RTL and testbench



---
 rtl/alarm_sched.sv | 161 ++++++++++++++++
 tb/tb_alarm_sched.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sched.sv
// rtl/alarm_sched.sv - alarm compare/ring/snooze sequencer for the wall clock (optional ALARM_BLINK_EN)
module alarm_sched #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tick_1hz,
    input  logic [19:0] cur_time,
    input  logic        arm_en,
    input  logic        alarm_wr,
    input  logic [19:0] alarm_wdata,
    input  logic        stop,
    input  logic        snooze,
    output logic        ring,
    output logic [19:0] alarm_time,
    output logic [1:0]  phase,
    output logic [2:0]  snooze_used,
    output logic        wr_err,
    output logic        missed
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZING = 2'd3
    } phase_t;

    phase_t     state;
    logic [9:0] cnt;
    logic       wr_ok;
    logic       wr_acc;
    logic       snooze_ok;
    logic       alarm_hit;
    logic       ring_tick;
    logic       wake;
    logic       blink_gate;

    // Packed BCD {hh,hl,mh,ml,sh,sl}; hours limited to 00..23
    function automatic logic time_valid(input logic [19:0] t);
        logic ok;
        ok = (t[3:0] <= 4'd9) && (t[6:4] <= 3'd5) &&
             (t[10:7] <= 4'd9) && (t[13:11] <= 3'd5) &&
             (t[17:14] <= 4'd9) && (t[19:18] <= 2'd2);
        if (t[19:18] == 2'd2 && t[17:14] > 4'd3)
            ok = 1'b0;
        return ok;
    endfunction

    assign wr_ok     = time_valid(alarm_wdata);
    assign wr_acc    = alarm_wr && wr_ok;
    assign snooze_ok = snooze && (snooze_used < 3'(MAX_SNOOZE));

    // Qualified events after applying arm_en > stop > write > snooze > tick
    assign alarm_hit = arm_en && (state == ARMED) && !stop && !wr_acc &&
                       tick_1hz && (cur_time == alarm_time);
    assign ring_tick = arm_en && (state == RINGING) && !stop && !wr_acc &&
                       !snooze_ok && tick_1hz;
    assign wake      = arm_en && (state == SNOOZING) && !stop && !wr_acc &&
                       tick_1hz && (cnt == 10'd1);

`ifdef ALARM_BLINK_EN
    logic blink;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            blink <= 1'b0;
        else if (alarm_hit || wake)
            blink <= 1'b1;
        else if (ring_tick)
            blink <= ~blink;
        else if (!(arm_en && state == RINGING))
            blink <= 1'b0;
    end

    assign blink_gate = blink;
`else
    assign blink_gate = 1'b1;
`endif

    assign phase = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= DISARMED;
            alarm_time  <= 20'd0;
            cnt         <= 10'd0;
            snooze_used <= 3'd0;
            wr_err      <= 1'b0;
            missed      <= 1'b0;
            ring        <= 1'b0;
        end else begin
            wr_err <= alarm_wr && !wr_ok;
            if (wr_acc)
                alarm_time <= alarm_wdata;
            ring <= arm_en && (state == RINGING) && blink_gate;

            if (!arm_en) begin
                state       <= DISARMED;
                snooze_used <= 3'd0;
            end else begin
                case (state)
                    DISARMED: begin
                        state       <= ARMED;
                        snooze_used <= 3'd0;
                    end
                    ARMED: begin
                        snooze_used <= 3'd0;
                        if (stop)
                            missed <= 1'b0;
                        else if (alarm_hit) begin
                            state <= RINGING;
                            cnt   <= 10'(RING_SECS);
                        end
                    end
                    RINGING: begin
                        if (stop) begin
                            state       <= ARMED;
                            missed      <= 1'b0;
                            snooze_used <= 3'd0;
                        end else if (wr_acc) begin
                            state       <= ARMED;
                            snooze_used <= 3'd0;
                        end else if (snooze_ok) begin
                            state       <= SNOOZING;
                            cnt         <= 10'(SNOOZE_SECS);
                            snooze_used <= snooze_used + 3'd1;
                        end else if (ring_tick) begin
                            if (cnt == 10'd1) begin
                                state       <= ARMED;
                                missed      <= 1'b1;
                                snooze_used <= 3'd0;
                            end else begin
                                cnt <= cnt - 10'd1;
                            end
                        end
                    end
                    SNOOZING: begin
                        if (stop) begin
                            state       <= ARMED;
                            missed      <= 1'b0;
                            snooze_used <= 3'd0;
                        end else if (wr_acc) begin
                            state       <= ARMED;
                            snooze_used <= 3'd0;
                        end else if (wake) begin
                            state <= RINGING;
                            cnt   <= 10'(RING_SECS);
                        end else if (tick_1hz) begin
                            cnt <= cnt - 10'd1;
                        end
                    end
                    default: state <= DISARMED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_sched.sv
// tb/tb_alarm_sched.sv - directed self-checking bench for alarm_sched
module tb_alarm_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tick_1hz;
    logic [19:0] cur_time;
    logic        arm_en;
    logic        alarm_wr;
    logic [19:0] alarm_wdata;
    logic        stop;
    logic        snooze;
    logic        ring;
    logic [19:0] alarm_time;
    logic [1:0]  phase;
    logic [2:0]  snooze_used;
    logic        wr_err;
    logic        missed;

    int total = 0;
    int bad   = 0;

    localparam logic [19:0] T0730 = {2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0};
    localparam logic [19:0] T0729 = {2'd0, 4'd7, 3'd2, 4'd9, 3'd5, 4'd9};
    localparam logic [19:0] T0731 = {2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd1};
    localparam logic [19:0] T2400 = {2'd2, 4'd4, 3'd0, 4'd0, 3'd0, 4'd0};
    localparam logic [19:0] T1260 = {2'd1, 4'd2, 3'd6, 4'd0, 3'd0, 4'd0};
    localparam logic [19:0] T2359 = {2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9};

    alarm_sched dut (
        .clk        (clk),
        .rstn       (rstn),
        .tick_1hz   (tick_1hz),
        .cur_time   (cur_time),
        .arm_en     (arm_en),
        .alarm_wr   (alarm_wr),
        .alarm_wdata(alarm_wdata),
        .stop       (stop),
        .snooze     (snooze),
        .ring       (ring),
        .alarm_time (alarm_time),
        .phase      (phase),
        .snooze_used(snooze_used),
        .wr_err     (wr_err),
        .missed     (missed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic do_write(input logic [19:0] t);
        alarm_wdata = t;
        alarm_wr    = 1'b1;
        step();
        alarm_wr    = 1'b0;
    endtask

    task automatic do_snooze();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; tick_1hz = 1'b0; cur_time = 20'd0; arm_en = 1'b0;
        alarm_wr = 1'b0; alarm_wdata = 20'd0; stop = 1'b0; snooze = 1'b0;
        step();
        step();
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_time", 32'(alarm_time), 32'd0);
        check("rst_ring", 32'(ring), 32'd0);
        check("rst_su", 32'(snooze_used), 32'd0);
        check("rst_wrerr", 32'(wr_err), 32'd0);
        check("rst_missed", 32'(missed), 32'd0);
        rstn = 1'b1;
        step();

        arm_en = 1'b1;
        step();
        check("arm_phase", 32'(phase), 32'd1);
        do_write(T0730);
        check("wr_time", 32'(alarm_time), 32'(T0730));
        check("wr_ok_noerr", 32'(wr_err), 32'd0);

        cur_time = T0729;
        do_tick();
        check("nomatch_phase", 32'(phase), 32'd1);
        cur_time = T0730;
        do_tick();
        check("hit_phase", 32'(phase), 32'd2);
        check("hit_ring_lat", 32'(ring), 32'd0);
        cur_time = T0731;
        step();
        check("hit_ring", 32'(ring), 32'd1);

        for (int i = 0; i < 59; i++) begin
            do_tick();
            step();
        end
        check("ring59_phase", 32'(phase), 32'd2);
        do_tick();
        check("timeout_phase", 32'(phase), 32'd1);
        check("timeout_missed", 32'(missed), 32'd1);
        step();
        check("timeout_ring", 32'(ring), 32'd0);

        cur_time = T0730;
        do_tick();
        cur_time = T0731;
        check("ring2_phase", 32'(phase), 32'd2);
        step();
        for (int k = 1; k <= 3; k++) begin
            do_snooze();
            check("snz_phase", 32'(phase), 32'd3);
            check("snz_used", 32'(snooze_used), 32'(k));
            step();
            check("snz_ring", 32'(ring), 32'd0);
            for (int i = 0; i < 299; i++) begin
                do_tick();
                step();
            end
            check("snz299_phase", 32'(phase), 32'd3);
            do_tick();
            check("wake_phase", 32'(phase), 32'd2);
            step();
            check("wake_ring", 32'(ring), 32'd1);
        end
        do_snooze();
        check("snz4_phase", 32'(phase), 32'd2);
        check("snz4_used", 32'(snooze_used), 32'd3);
        check("snz_missed_kept", 32'(missed), 32'd1);

        stop = 1'b1; snooze = 1'b1;
        step();
        stop = 1'b0; snooze = 1'b0;
        check("stopsnz_phase", 32'(phase), 32'd1);
        check("stopsnz_used", 32'(snooze_used), 32'd0);
        check("stopsnz_missed", 32'(missed), 32'd0);

        do_write(T2400);
        check("w2400_err", 32'(wr_err), 32'd1);
        check("w2400_time", 32'(alarm_time), 32'(T0730));
        step();
        check("werr_pulse", 32'(wr_err), 32'd0);
        do_write(T1260);
        check("w1260_err", 32'(wr_err), 32'd1);
        check("w1260_time", 32'(alarm_time), 32'(T0730));
        do_write(T2359);
        check("w2359_err", 32'(wr_err), 32'd0);
        check("w2359_time", 32'(alarm_time), 32'(T2359));

        cur_time = T2359;
        do_tick();
        check("ring3_phase", 32'(phase), 32'd2);
        do_snooze();
        check("ring3_snz", 32'(phase), 32'd3);
        arm_en = 1'b0;
        step();
        check("disarm_phase", 32'(phase), 32'd0);
        check("disarm_su", 32'(snooze_used), 32'd0);
        do_tick();
        step();
        check("disarm_nohit", 32'(phase), 32'd0);
        check("disarm_ring", 32'(ring), 32'd0);
        arm_en = 1'b1;
        step();
        check("rearm_phase", 32'(phase), 32'd1);

        do_tick();
        check("blink_phase", 32'(phase), 32'd2);
        step();
        check("blink_r0", 32'(ring), 32'd1);
        for (int i = 1; i < 4; i++) begin
            do_tick();
            step();
`ifdef ALARM_BLINK_EN
            check("blink_rn", 32'(ring), (i % 2 == 1) ? 32'd0 : 32'd1);
`else
            check("steady_rn", 32'(ring), 32'd1);
`endif
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_phase", 32'(phase), 32'd1);

        do_tick();
        step();
        step();
        check("pre_rst_ring", 32'(ring), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_ring", 32'(ring), 32'd0);
        check("arst_phase", 32'(phase), 32'd0);
        check("arst_time", 32'(alarm_time), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
